lq_agen_split: RTL and testbench

Parametrised load/store address-generation stage with line-crossing split sequencing. Adds base and offset to form the effective address. Extracts the directory/array set index, with an optional force of the index LSB. Emits one beat per access, or two beats when the access straddles a cache line. Sits between the LQ issue/execute stage and the directory/data-array lookup, behind a valid/ready handshake on both sides.

---
 rtl/lq_agen_pkg.sv | 35 +++
 rtl/lq_agen_split_if.sv | 37 +++
 rtl/lq_agen_add.sv | 29 ++
 rtl/lq_agen_split.sv | 168 ++++++++++++++++
 tb/tb_lq_agen_split.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lq_agen_pkg.sv
// lq_agen_pkg: shared types and helpers for the load-queue address-generation stage.
//   - agen_state_e : beat-holding FSM states
//   - size_to_bytes: log2 access size -> byte count, clamped to 16 B
//   - idx_of       : set index of an effective address with optional LSB force
package lq_agen_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold1,
        StHold2
    } agen_state_e;

    localparam int unsigned MaxWidth     = 64;
    localparam int unsigned DefLineLog2  = 6;
    localparam int unsigned DefLineBytes = 1 << DefLineLog2;

    // Sizes above 16 B are treated as 16 B.
    function automatic logic [4:0] size_to_bytes(input logic [2:0] size);
        logic [2:0] clamped;
        clamped = (size > 3'd4) ? 3'd4 : size;
        return 5'd1 << clamped;
    endfunction

    // Index = (ea >> line_log2) mod 2^idx_width, LSB ORed with dir_ig.
    // Returned at full width; callers narrow it to their index width.
    function automatic logic [MaxWidth-1:0] idx_of(input logic [MaxWidth-1:0] ea,
                                                   input int unsigned line_log2,
                                                   input int unsigned idx_width,
                                                   input logic dir_ig);
        logic [MaxWidth-1:0] mask;
        mask = (64'd1 << idx_width) - 64'd1;
        return ((ea >> line_log2) & mask) | {63'd0, dir_ig};
    endfunction

endpackage

// File: rtl/lq_agen_split_if.sv
// lq_agen_split_if: request (ex_*) and beat (agen_*) handshakes of the AGEN stage.
//   master : issue/execute side plus beat consumer (drives ex_*, agen_rdy)
//   slave  : the AGEN stage (drives ex_rdy, agen_*)
interface lq_agen_split_if #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned IDX_WIDTH = 6
);
    logic                 ex_vld;
    logic                 ex_rdy;
    logic [WIDTH-1:0]     ex_base;
    logic [WIDTH-1:0]     ex_offset;
    logic [2:0]           ex_size;
    logic                 ex_dir_ig;
    logic                 ex_mode64;

    logic                 agen_vld;
    logic                 agen_rdy;
    logic [WIDTH-1:0]     agen_ea;
    logic [IDX_WIDTH-1:0] agen_idx;
    logic [4:0]           agen_bytes;
    logic                 agen_split;
    logic                 agen_last;
    logic                 agen_cout;

    modport master (
        output ex_vld, ex_base, ex_offset, ex_size, ex_dir_ig, ex_mode64, agen_rdy,
        input  ex_rdy, agen_vld, agen_ea, agen_idx, agen_bytes, agen_split, agen_last,
               agen_cout
    );

    modport slave (
        input  ex_vld, ex_base, ex_offset, ex_size, ex_dir_ig, ex_mode64, agen_rdy,
        output ex_rdy, agen_vld, agen_ea, agen_idx, agen_bytes, agen_split, agen_last,
               agen_cout
    );

endinterface

// File: rtl/lq_agen_add.sv
// lq_agen_add: WIDTH-bit adder for effective-address generation.
//   a, b      : operands
//   mode64    : 0 clears sum bits >= 32 (32-bit wrap)
//   sum       : a + b at the selected mode width
//   carry31   : carry out of bit 31
//   carry_top : carry out of bit WIDTH-1
module lq_agen_add #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode64,
    output logic [WIDTH-1:0] sum,
    output logic             carry31,
    output logic             carry_top
);

    localparam logic [WIDTH-1:0] Mask32 = WIDTH'(64'h0000_0000_FFFF_FFFF);

    logic [WIDTH:0] full;
    logic [32:0]    low;

    assign full      = {1'b0, a} + {1'b0, b};
    assign low       = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    assign carry_top = full[WIDTH];
    assign carry31   = low[32];
    assign sum       = mode64 ? full[WIDTH-1:0] : (full[WIDTH-1:0] & Mask32);

endmodule

// File: rtl/lq_agen_split.sv
// lq_agen_split: load/store address generation with cache-line split sequencing.
//   clk, rst_b : clock, asynchronous active-low reset
//   bus        : slave side of lq_agen_split_if
//                ex_*   request in (base, offset, size, dir_ig, mode64) with ex_vld/ex_rdy
//                agen_* registered beat out (ea, idx, bytes, split, last, cout)
// A request that fits in one line yields one beat; one that crosses a line boundary
// yields a first beat up to the line end and a second, line-aligned beat with the rest.
module lq_agen_split
    import lq_agen_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned LINE_LOG2 = 6,
    parameter int unsigned IDX_WIDTH = 6
) (
    input logic            clk,
    input logic            rst_b,
    lq_agen_split_if.slave bus
);

    localparam int unsigned LineBytes  = 1 << LINE_LOG2;
    localparam logic [8:0]  LineBytes9 = 9'(LineBytes);

    agen_state_e          state_q, state_d;
    logic [WIDTH-1:0]     ea_q, ea_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [4:0]           bytes_q, bytes_d;
    logic [4:0]           rem_q, rem_d;
    logic                 split_q, split_d;
    logic                 last_q, last_d;
    logic                 cout_q, cout_d;
    logic                 dir_ig_q, dir_ig_d;
    logic                 mode64_q, mode64_d;

    // base + offset for the incoming request
    logic [WIDTH-1:0] sum;
    logic             sum_c31, sum_ctop;

    lq_agen_add #(
        .WIDTH(WIDTH)
    ) u_add_ea (
        .a        (bus.ex_base),
        .b        (bus.ex_offset),
        .mode64   (bus.ex_mode64),
        .sum      (sum),
        .carry31  (sum_c31),
        .carry_top(sum_ctop)
    );

    // held first-beat ea + its byte count -> next line for the second beat
    logic [WIDTH-1:0] nxt_ea;
    logic             nxt_c31, nxt_ctop;

    lq_agen_add #(
        .WIDTH(WIDTH)
    ) u_add_next (
        .a        (ea_q),
        .b        (WIDTH'(bytes_q)),
        .mode64   (mode64_q),
        .sum      (nxt_ea),
        .carry31  (nxt_c31),
        .carry_top(nxt_ctop)
    );

    logic                 accept, consume;
    logic [4:0]           req_bytes, first_bytes;
    logic [8:0]           line_off, span;
    logic                 needs_split;
    logic                 new_cout, nxt_wrap;
    logic [IDX_WIDTH-1:0] new_idx, nxt_idx;

    assign req_bytes   = size_to_bytes(bus.ex_size);
    assign line_off    = 9'(sum[LINE_LOG2-1:0]);
    assign span        = line_off + 9'(req_bytes);
    assign needs_split = span > LineBytes9;
    // Only meaningful when splitting; then it is strictly below req_bytes.
    assign first_bytes = 5'(LineBytes9 - line_off);
    assign new_cout    = bus.ex_mode64 ? sum_ctop : sum_c31;
    assign new_idx     = IDX_WIDTH'(idx_of(64'(sum), LINE_LOG2, IDX_WIDTH, bus.ex_dir_ig));
    assign nxt_idx     = IDX_WIDTH'(idx_of(64'(nxt_ea), LINE_LOG2, IDX_WIDTH, dir_ig_q));

    // The increment lands on a line boundary, so a mode-width carry and a zero result
    // coincide; either marks the wrap.
    assign nxt_wrap = (mode64_q ? nxt_ctop : nxt_c31) | (nxt_ea == '0);

    // Ready only when no beat is held or the held final beat leaves this cycle.
    assign bus.ex_rdy = (state_q == StIdle) || (last_q && bus.agen_rdy);
    assign accept     = bus.ex_vld && bus.ex_rdy;
    assign consume    = (state_q != StIdle) && bus.agen_rdy;

    always_comb begin
        state_d  = state_q;
        ea_d     = ea_q;
        idx_d    = idx_q;
        bytes_d  = bytes_q;
        rem_d    = rem_q;
        split_d  = split_q;
        last_d   = last_q;
        cout_d   = cout_q;
        dir_ig_d = dir_ig_q;
        mode64_d = mode64_q;

        if (accept) begin
            // Covers both IDLE and a final beat leaving this cycle: no bubble.
            state_d  = StHold1;
            ea_d     = sum;
            idx_d    = new_idx;
            dir_ig_d = bus.ex_dir_ig;
            mode64_d = bus.ex_mode64;
            cout_d   = new_cout;
            split_d  = needs_split;
            last_d   = !needs_split;
            bytes_d  = needs_split ? first_bytes : req_bytes;
            rem_d    = needs_split ? (req_bytes - first_bytes) : 5'd0;
        end else if (consume) begin
            case (state_q)
                StHold1: begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold2;
                        ea_d    = nxt_ea;
                        idx_d   = nxt_idx;
                        bytes_d = rem_q;
                        last_d  = 1'b1;
                        cout_d  = cout_q | nxt_wrap;
                    end
                end
                StHold2: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= StIdle;
            ea_q     <= '0;
            idx_q    <= '0;
            bytes_q  <= '0;
            rem_q    <= '0;
            split_q  <= 1'b0;
            last_q   <= 1'b0;
            cout_q   <= 1'b0;
            dir_ig_q <= 1'b0;
            mode64_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ea_q     <= ea_d;
            idx_q    <= idx_d;
            bytes_q  <= bytes_d;
            rem_q    <= rem_d;
            split_q  <= split_d;
            last_q   <= last_d;
            cout_q   <= cout_d;
            dir_ig_q <= dir_ig_d;
            mode64_q <= mode64_d;
        end
    end

    assign bus.agen_vld   = (state_q != StIdle);
    assign bus.agen_ea    = ea_q;
    assign bus.agen_idx   = idx_q;
    assign bus.agen_bytes = bytes_q;
    assign bus.agen_split = split_q;
    assign bus.agen_last  = last_q;
    assign bus.agen_cout  = cout_q;

endmodule

// File: tb/tb_lq_agen_split.sv
// tb_lq_agen_split: directed plus randomized checks of lq_agen_split against a
// beat-list reference model (WIDTH=64, LINE_LOG2=6, IDX_WIDTH=6).
module tb_lq_agen_split;

    typedef struct {
        logic [63:0] ea;
        logic [5:0]  idx;
        logic [4:0]  bytes;
        logic        split;
        logic        last;
        logic        cout;
    } beat_t;

    logic clk = 1'b0;
    logic rst_b;
    int   vectors = 0;
    int   miscompares = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    lq_agen_split_if #(.WIDTH(64), .IDX_WIDTH(6)) bus_if ();

    lq_agen_split #(
        .WIDTH    (64),
        .LINE_LOG2(6),
        .IDX_WIDTH(6)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus_if.slave)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ref_idx(input logic [63:0] ea, input logic dir);
        return 6'((ea / 64) % 64) | {5'd0, dir};
    endfunction

    // Expected beats of one request, appended to the pending-beat queue.
    function automatic void model_push(input logic [63:0] base, input logic [63:0] ofs,
                                       input logic [2:0] size, input logic dir,
                                       input logic m64);
        logic [64:0] full;
        logic [63:0] ea, ea2;
        logic        c;
        int unsigned n, lo, first;
        beat_t       b;
        if (m64) begin
            full = {1'b0, base} + {1'b0, ofs};
            ea   = full[63:0];
            c    = full[64];
        end else begin
            full = 65'(base[31:0]) + 65'(ofs[31:0]);
            ea   = {32'd0, full[31:0]};
            c    = full[32];
        end
        n  = 1 << ((size > 3'd4) ? 4 : int'(size));
        lo = int'(ea % 64);
        b.ea   = ea;
        b.idx  = ref_idx(ea, dir);
        b.cout = c;
        if (lo + n <= 64) begin
            b.bytes = 5'(n);
            b.split = 1'b0;
            b.last  = 1'b1;
            q.push_back(b);
        end else begin
            first   = 64 - lo;
            b.bytes = 5'(first);
            b.split = 1'b1;
            b.last  = 1'b0;
            q.push_back(b);
            ea2 = ea + 64'(first);
            if (!m64) ea2 = ea2 & 64'h0000_0000_FFFF_FFFF;
            b.ea    = ea2;
            b.idx   = ref_idx(ea2, dir);
            b.bytes = 5'(n - first);
            b.last  = 1'b1;
            b.cout  = c | (ea2 == 64'd0);
            q.push_back(b);
        end
    endfunction

    // One clock: compare outputs with the model, retire/accept, advance to edge + 1.
    task automatic cycle();
        logic exp_rdy;
        #1;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && bus_if.agen_rdy);
        chk("ex_rdy", 64'(bus_if.ex_rdy), 64'(exp_rdy));
        chk("agen_vld", 64'(bus_if.agen_vld), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("ea", bus_if.agen_ea, q[0].ea);
            chk("idx", 64'(bus_if.agen_idx), 64'(q[0].idx));
            chk("bytes", 64'(bus_if.agen_bytes), 64'(q[0].bytes));
            chk("split", 64'(bus_if.agen_split), 64'(q[0].split));
            chk("last", 64'(bus_if.agen_last), 64'(q[0].last));
            chk("cout", 64'(bus_if.agen_cout), 64'(q[0].cout));
            if (bus_if.agen_rdy) void'(q.pop_front());
        end
        if (bus_if.ex_vld && exp_rdy)
            model_push(bus_if.ex_base, bus_if.ex_offset, bus_if.ex_size, bus_if.ex_dir_ig,
                       bus_if.ex_mode64);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [63:0] base, input logic [63:0] ofs,
                           input logic [2:0] size, input logic dir, input logic m64);
        bus_if.ex_vld    = 1'b1;
        bus_if.ex_base   = base;
        bus_if.ex_offset = ofs;
        bus_if.ex_size   = size;
        bus_if.ex_dir_ig = dir;
        bus_if.ex_mode64 = m64;
    endtask

    task automatic drain();
        bus_if.ex_vld   = 1'b0;
        bus_if.agen_rdy = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) cycle();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_b = 1'b0;
        bus_if.agen_rdy = 1'b0;
        set_req(64'd0, 64'd0, 3'd0, 1'b0, 1'b1);
        bus_if.ex_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 64'(bus_if.agen_vld), 64'd0);
        chk("rst_rdy", 64'(bus_if.ex_rdy), 64'd1);
        chk("rst_ea", bus_if.agen_ea, 64'd0);
        chk("rst_idx", 64'(bus_if.agen_idx), 64'd0);
        chk("rst_bytes", 64'(bus_if.agen_bytes), 64'd0);
        chk("rst_flags", 64'({bus_if.agen_split, bus_if.agen_last, bus_if.agen_cout}), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Simple beat
        bus_if.agen_rdy = 1'b1;
        set_req(64'h1000, 64'h38, 3'd3, 1'b0, 1'b1);
        cycle();
        bus_if.ex_vld = 1'b0;
        chk("simple_ea", bus_if.agen_ea, 64'h1038);
        chk("simple_bytes", 64'(bus_if.agen_bytes), 64'd8);
        chk("simple_last", 64'(bus_if.agen_last), 64'd1);
        drain();

        // Index force
        set_req(64'h100, 64'h80, 3'd0, 1'b0, 1'b1);
        cycle();
        bus_if.ex_vld = 1'b0;
        chk("idx_plain", 64'(bus_if.agen_idx), 64'd6);
        drain();
        set_req(64'h100, 64'h80, 3'd0, 1'b1, 1'b1);
        cycle();
        bus_if.ex_vld = 1'b0;
        chk("idx_force", 64'(bus_if.agen_idx), 64'd7);
        drain();

        // Split with the first beat held off for a cycle
        bus_if.agen_rdy = 1'b0;
        set_req(64'h2000, 64'h3C, 3'd3, 1'b0, 1'b1);
        cycle();
        bus_if.ex_vld = 1'b1;
        chk("split1_ea", bus_if.agen_ea, 64'h203C);
        chk("split1_bytes", 64'(bus_if.agen_bytes), 64'd4);
        chk("split1_last", 64'(bus_if.agen_last), 64'd0);
        chk("split1_rdy", 64'(bus_if.ex_rdy), 64'd0);
        bus_if.ex_vld   = 1'b0;
        bus_if.agen_rdy = 1'b1;
        cycle();
        chk("split2_ea", bus_if.agen_ea, 64'h2040);
        chk("split2_bytes", 64'(bus_if.agen_bytes), 64'd4);
        chk("split2_last", 64'(bus_if.agen_last), 64'd1);
        drain();

        // Mode32 wrap across 2^32
        set_req(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 3'd3, 1'b0, 1'b0);
        cycle();
        bus_if.ex_vld = 1'b0;
        chk("m32_b1_ea", bus_if.agen_ea, 64'hFFFF_FFFC);
        cycle();
        chk("m32_b2_ea", bus_if.agen_ea, 64'd0);
        chk("m32_b2_cout", 64'(bus_if.agen_cout), 64'd1);
        drain();
        set_req(64'h1_0000_0010, 64'd0, 3'd2, 1'b0, 1'b0);
        cycle();
        bus_if.ex_vld = 1'b0;
        chk("m32_trunc_ea", bus_if.agen_ea, 64'h10);
        drain();

        // Backpressure with changing unaccepted requests, then 4-deep streaming
        set_req(64'h3000, 64'h8, 3'd2, 1'b0, 1'b1);
        cycle();
        bus_if.agen_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req({$urandom(), $urandom()}, {$urandom(), $urandom()}, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'b1);
            cycle();
        end
        bus_if.agen_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(64'h4000 + 64'(i * 64), 64'(i * 8), 3'd3, 1'b0, 1'b1);
            cycle();
        end
        drain();

        // Reset during a split's first beat
        bus_if.agen_rdy = 1'b0;
        set_req(64'h5000, 64'h3E, 3'd4, 1'b0, 1'b1);
        cycle();
        bus_if.ex_vld = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(bus_if.agen_vld), 64'd0);
        chk("mid_rst_rdy", 64'(bus_if.ex_rdy), 64'd1);
        q.delete();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        bus_if.agen_rdy = 1'b1;
        for (int i = 0; i < 3; i++) cycle();

        // Randomized traffic, biased toward line-crossing offsets
        for (int i = 0; i < 400; i++) begin
            set_req({$urandom(), $urandom()},
                    ($urandom_range(0, 1) != 0) ? {$urandom(), $urandom()}
                                                : 64'($urandom_range(0, 200)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            bus_if.ex_vld   = ($urandom_range(0, 3) != 0);
            bus_if.agen_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
